// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction memory loader.
// Optional checksum stage is enabled by defining IMEM_LOADER_CHECKSUM_EN.
package imem_loader_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StHdr,
      StData,
      StWrite,
`ifdef IMEM_LOADER_CHECKSUM_EN
      StChk,
`endif
      StDone
   } state_e;

   localparam int unsigned WORD_BYTES = 4;
   localparam int unsigned LANE_W     = 8;

   // Big-endian lane placement: first byte lands in the top of the word.
   localparam int unsigned LANE0_LSB = 24;
   localparam int unsigned LANE1_LSB = 16;
   localparam int unsigned LANE2_LSB = 8;
   localparam int unsigned LANE3_LSB = 0;

   localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h0000_0000;
   localparam int unsigned DEFAULT_MAX_WORDS = 256;

   function automatic int unsigned lane_lsb(input logic [1:0] lane);
      unique case (lane)
         2'd0:    return LANE0_LSB;
         2'd1:    return LANE1_LSB;
         2'd2:    return LANE2_LSB;
         default: return LANE3_LSB;
      endcase
   endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte stream handshake plus instruction memory write port.
// master: loader side; slave: byte source and memory side.
interface imem_loader_if;
   logic        in_valid;
   logic [7:0]  in_data;
   logic        in_ready;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;

   modport master (
      input  in_valid,
      input  in_data,
      output in_ready,
      output mem_we,
      output mem_addr,
      output mem_wdata
   );

   modport slave (
      output in_valid,
      output in_data,
      input  in_ready,
      input  mem_we,
      input  mem_addr,
      input  mem_wdata
   );
endinterface

// File: rtl/imem_loader_byte_assembler.sv
// Collects four stream bytes into one big-endian instruction word.
module byte_assembler
   import imem_loader_pkg::*;
(
   input  logic        clk,
   input  logic        reset_n,
   input  logic [7:0]  byte_i,
   input  logic        accept_i,
   input  logic        clear_i,
   output logic [31:0] word_o,
   output logic        word_full_o
);

   logic [1:0]  lane_q, lane_d;
   logic [31:0] word_q, word_d;

   // Next lane/word: clear wins, otherwise drop the accepted byte into its lane.
   always_comb begin
      lane_d = lane_q;
      word_d = word_q;
      if (clear_i) begin
         lane_d = 2'd0;
         word_d = '0;
      end else if (accept_i) begin
         word_d[lane_lsb(lane_q) +: LANE_W] = byte_i;
         lane_d = lane_q + 2'd1;
      end
   end

   // Lane counter and word register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         lane_q <= 2'd0;
         word_q <= '0;
      end else begin
         lane_q <= lane_d;
         word_q <= word_d;
      end
   end

   // Full is flagged in the cycle the last lane is being accepted.
   always_comb begin
      word_o      = word_q;
      word_full_o = accept_i && (lane_q == 2'(WORD_BYTES - 1));
   end

endmodule

// File: rtl/imem_loader.sv
// Loads a program image from a byte stream into instruction memory.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR,
   parameter int unsigned MAX_WORDS = DEFAULT_MAX_WORDS
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            start,
   imem_loader_if.master   bus,
   output logic            busy,
   output logic            done,
   output logic            error,
   output logic            cpu_hold
);

   state_e      state_q, state_d;
   logic [31:0] addr_q, addr_d;
   logic [7:0]  remain_q, remain_d;
   logic        error_q, error_d;
   logic        accept, start_load, hdr_bad, word_full;
   logic [31:0] word;
`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [7:0]  xor_q, xor_d;
`endif

   assign accept     = bus.in_valid && bus.in_ready;
   assign start_load = start && (state_q == StIdle || state_q == StDone);
   assign hdr_bad    = (bus.in_data == 8'd0) || (32'(bus.in_data) > MAX_WORDS);

   byte_assembler u_asm (
      .clk         (clk),
      .reset_n     (reset_n),
      .byte_i      (bus.in_data),
      .accept_i    (accept && state_q == StData),
      .clear_i     (start_load),
      .word_o      (word),
      .word_full_o (word_full)
   );

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= StIdle;
      else          state_q <= state_d;
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle, StDone: if (start) state_d = StHdr;
         StHdr:          if (accept) state_d = hdr_bad ? StIdle : StData;
         StData:         if (word_full) state_d = StWrite;
         StWrite: begin
            if (remain_q == 8'd1) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
               state_d = StChk;
`else
               state_d = StDone;
`endif
            end else begin
               state_d = StData;
            end
         end
`ifdef IMEM_LOADER_CHECKSUM_EN
         StChk:          if (accept) state_d = (bus.in_data == xor_q) ? StDone : StIdle;
`endif
         default:        state_d = StIdle;
      endcase
   end

   // Address, remaining-word, error and checksum next-state.
   always_comb begin
      addr_d   = addr_q;
      remain_d = remain_q;
      error_d  = error_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
      xor_d    = xor_q;
      if (state_q == StData && accept) xor_d = xor_q ^ bus.in_data;
      if (state_q == StChk && accept && bus.in_data != xor_q) error_d = 1'b1;
      if (start_load) xor_d = 8'd0;
`endif
      if (start_load) begin
         addr_d  = BASE_ADDR;
         error_d = 1'b0;
      end
      if (state_q == StHdr && accept) begin
         if (hdr_bad) error_d  = 1'b1;
         else         remain_d = bus.in_data;
      end
      if (state_q == StWrite) begin
         addr_d   = addr_q + 32'd4;
         remain_d = remain_q - 8'd1;
      end
   end

   // Datapath registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         addr_q   <= BASE_ADDR;
         remain_q <= 8'd0;
         error_q  <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
         xor_q    <= 8'd0;
`endif
      end else begin
         addr_q   <= addr_d;
         remain_q <= remain_d;
         error_q  <= error_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
         xor_q    <= xor_d;
`endif
      end
   end

   // Outputs decoded from state so mem_we drops as soon as reset asserts.
   always_comb begin
      bus.in_ready  = (state_q == StHdr) || (state_q == StData)
`ifdef IMEM_LOADER_CHECKSUM_EN
                      || (state_q == StChk)
`endif
                      ;
      bus.mem_we    = (state_q == StWrite);
      bus.mem_addr  = addr_q;
      bus.mem_wdata = word;
      busy          = (state_q != StIdle) && (state_q != StDone);
      cpu_hold      = busy;
      done          = (state_q == StDone);
      error         = error_q;
   end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader; expected writes are queued by the stimulus
// and popped by a monitor whenever the DUT strobes mem_we.
module tb_imem_loader;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic start = 1'b0;
   logic busy, done, error, cpu_hold;

   imem_loader_if bus ();

   imem_loader #(
      .BASE_ADDR (32'h0000_0000),
      .MAX_WORDS (8)
   ) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .start    (start),
      .bus      (bus),
      .busy     (busy),
      .done     (done),
      .error    (error),
      .cpu_hold (cpu_hold)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
   } wr_t;

   wr_t         exp_q[$];
   logic [31:0] words[$];
   int          total = 0;
   int          bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   // Monitor: every write strobe must match the oldest expected write.
   always @(negedge clk) begin
      if (reset_n && bus.mem_we) begin
         wr_t e;
         check("in_ready_in_write", {31'd0, bus.in_ready}, 32'd0);
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_write: got addr %h data %h want none",
                     bus.mem_addr, bus.mem_wdata);
         end else begin
            e = exp_q.pop_front();
            check("wr_addr", bus.mem_addr, e.addr);
            check("wr_data", bus.mem_wdata, e.data);
         end
      end
   end

   // All tasks enter and leave 1 time unit after a rising edge.
   task automatic send_byte(input logic [7:0] b, input bit gap);
      bit hs;
      int guard;
      if (gap && $urandom_range(0, 1) == 1) begin
         bus.in_valid = 1'b0;
         @(posedge clk);
         #1;
      end
      bus.in_valid = 1'b1;
      bus.in_data  = b;
      hs    = 1'b0;
      guard = 0;
      while (!hs && guard < 50) begin
         @(negedge clk);
         hs = bus.in_ready;
         @(posedge clk);
         #1;
         guard++;
      end
      if (!hs) begin
         total++;
         bad++;
         $display("FAIL byte_handshake_timeout: got no in_ready want in_ready within 50 cycles");
      end
      bus.in_valid = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic wait_end();
      int n = 0;
      while (!(done || error) && n < 20) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (n >= 20) begin
         total++;
         bad++;
         $display("FAIL end_timeout: got busy after 20 cycles want done or error");
      end
   endtask

   // Full load of 'words'; optionally pulse start mid-word and corrupt the checksum.
   task automatic run_load(input bit gaps, input bit mid_start, input logic [7:0] chk_flip);
      logic [7:0] x;
      logic [7:0] b;
      logic [31:0] w;
      x = 8'd0;
      pulse_start();
      check("busy_after_start", {31'd0, busy}, 32'd1);
      check("hold_after_start", {31'd0, cpu_hold}, 32'd1);
      check("error_cleared", {31'd0, error}, 32'd0);
      send_byte(8'(words.size()), gaps);
      for (int i = 0; i < words.size(); i++) begin
         w = words[i];
         exp_q.push_back('{addr: 32'(4 * i), data: w});
         for (int k = 0; k < 4; k++) begin
            b = w[31 - 8 * k -: 8];
            x = x ^ b;
            if (mid_start && i == 0 && k == 2) pulse_start();
            send_byte(b, gaps);
         end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      send_byte(x ^ chk_flip, gaps);
`else
      b = chk_flip;
`endif
      wait_end();
   endtask

   task automatic check_ok(input int n);
      check("done", {31'd0, done}, 32'd1);
      check("busy_end", {31'd0, busy}, 32'd0);
      check("hold_end", {31'd0, cpu_hold}, 32'd0);
      check("error_end", {31'd0, error}, 32'd0);
      check("final_addr", bus.mem_addr, 32'(4 * n));
      check("all_writes_seen", 32'(exp_q.size()), 32'd0);
   endtask

   task automatic bad_header(input logic [7:0] h);
      pulse_start();
      send_byte(h, 1'b0);
      check("hdr_error", {31'd0, error}, 32'd1);
      check("hdr_busy", {31'd0, busy}, 32'd0);
      check("hdr_hold", {31'd0, cpu_hold}, 32'd0);
      check("hdr_done", {31'd0, done}, 32'd0);
      @(posedge clk);
      #1;
      check("hdr_in_ready", {31'd0, bus.in_ready}, 32'd0);
   endtask

   initial begin
      bus.in_valid = 1'b0;
      bus.in_data  = 8'd0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
      check("rst_mem_we", {31'd0, bus.mem_we}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_error", {31'd0, error}, 32'd0);
      check("rst_hold", {31'd0, cpu_hold}, 32'd0);
      check("rst_addr", bus.mem_addr, 32'h0);
      check("rst_wdata", bus.mem_wdata, 32'h0);
      reset_n = 1'b1;
      @(posedge clk);
      #1;

      // Basic three-word load.
      words = '{32'h2009_0002, 32'h2108_0001, 32'h1509_FFFE};
      run_load(1'b0, 1'b0, 8'd0);
      check_ok(3);

      // Illegal headers: zero, far above and just above capacity.
      bad_header(8'd0);
      bad_header(8'd255);
      bad_header(8'd9);

      // Two-word load with random valid gaps.
      words = '{32'h2009_0002, 32'h2108_0001};
      run_load(1'b1, 1'b0, 8'd0);
      check_ok(2);

      // Reset after two data bytes of the first word.
      pulse_start();
      send_byte(8'd2, 1'b0);
      send_byte(8'hDE, 1'b0);
      send_byte(8'hAD, 1'b0);
      reset_n = 1'b0;
      #1;
      check("midrst_mem_we", {31'd0, bus.mem_we}, 32'd0);
      check("midrst_in_ready", {31'd0, bus.in_ready}, 32'd0);
      check("midrst_busy", {31'd0, busy}, 32'd0);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      words = '{32'hCAFE_0001};
      run_load(1'b0, 1'b0, 8'd0);
      check_ok(1);

      // Reset while the write strobe is up drops it at once.
      pulse_start();
      send_byte(8'd1, 1'b0);
      send_byte(8'h01, 1'b0);
      send_byte(8'h02, 1'b0);
      send_byte(8'h03, 1'b0);
      send_byte(8'h04, 1'b0);
      check("pre_rst_we", {31'd0, bus.mem_we}, 32'd1);
      reset_n = 1'b0;
      #1;
      check("async_we_drop", {31'd0, bus.mem_we}, 32'd0);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      @(posedge clk);
      #1;

      // start during DATA is ignored.
      words = '{32'hA5A5_5A5A};
      run_load(1'b0, 1'b1, 8'd0);
      check_ok(1);

`ifdef IMEM_LOADER_CHECKSUM_EN
      words = '{32'h1122_3344};
      run_load(1'b0, 1'b0, 8'd0);
      check_ok(1);
      run_load(1'b0, 1'b0, 8'h01);
      check("chk_error", {31'd0, error}, 32'd1);
      check("chk_done", {31'd0, done}, 32'd0);
      check("chk_busy", {31'd0, busy}, 32'd0);
      check("chk_writes_seen", 32'(exp_q.size()), 32'd0);
`endif

      repeat (3) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Write-side counterpart to the instruction memory.
- Accepts a byte stream over a valid/ready handshake, assembles big-endian 32-bit instruction words, and issues one write per word to the instruction memory write port.
- Holds the CPU (`cpu_hold`) while a program image is loading.
- Sits between the boot/debug byte source and the instruction memory.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of the first instruction written; word-aligned.
- MAX_WORDS, 256, instruction memory capacity in words.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse; begins a load when the FSM is in IDLE.
- in_valid  input  1  in_data holds a valid byte.
- in_data  input  8  stream byte.
- in_ready  output  1  loader can accept a byte this cycle.
- mem_we  output  1  instruction memory write strobe, one cycle per word.
- mem_addr  output  32  byte address of the word being written.
- mem_wdata  output  32  assembled word; first-received byte in [31:24].
- busy  output  1  load in progress.
- done  output  1  load completed successfully; held until next start.
- error  output  1  load aborted; held until next start.
- cpu_hold  output  1  high while busy; CPU must not fetch.

Behaviour:
- Clock and reset: one clock. Reset is asynchronous, active-low, on reset_n.
- Reset values: in_ready, mem_we, busy, done, error, cpu_hold = 0; mem_addr = BASE_ADDR; mem_wdata = 0; FSM = IDLE.
- Byte acceptance: a byte is accepted only when in_valid && in_ready at a rising edge. in_ready is combinational from state only, never from in_valid.
- FSM states: IDLE, HDR, DATA, WRITE, CHK, DONE.
- IDLE:
  - start=1 → HDR.
  - Clears done and error, loads the address register with BASE_ADDR, clears the byte lane counter.
  - busy and cpu_hold go high on the next cycle.
- HDR (in_ready=1):
  - The accepted byte is the word count N.
  - N=0 or N>MAX_WORDS → error=1, go to IDLE.
  - Otherwise latch N and go to DATA.
- DATA (in_ready=1):
  - Accepted bytes shift into the word register MSB-first: lane 0→[31:24], lane 1→[23:16], lane 2→[15:8], lane 3→[7:0].
  - On the 4th byte → WRITE.
- WRITE (in_ready=0):
  - mem_we=1 for exactly one cycle, with mem_addr = current address and mem_wdata = assembled word.
  - Next cycle: address += 4 and remaining count -= 1.
  - Remaining count reaches 0 → CHK if IMEM_LOADER_CHECKSUM_EN is defined, else DONE. Otherwise → DATA.
- Latency: the write strobe is asserted in the cycle after the 4th byte is accepted. Minimum 5 cycles per word.
- DONE: done=1, busy=0, cpu_hold=0. start → behaves as from IDLE (restart).
- Error exit: in IDLE with error=1, busy=0 and cpu_hold=0.
- start while busy (HDR/DATA/WRITE/CHK): ignored.
- in_valid with no handshake (in_ready=0): byte not consumed; the source must hold it.
- Address wrap: not possible, because N≤MAX_WORDS is enforced. Final address = BASE_ADDR + 4N.
- Reset mid-load: immediate return to IDLE.
  - mem_we deasserts asynchronously.
  - The partial word is discarded.
  - Words already written remain in memory.

Optional Feature:
- IMEM_LOADER_CHECKSUM_EN defined:
  - After the last word, state CHK (in_ready=1) accepts one byte.
  - That byte must equal the XOR of all 4N data bytes (header excluded).
  - Match → DONE. Mismatch → error=1, IDLE, done=0.
  - The running XOR register is cleared on start.
- Not defined: no CHK state and no XOR register; the last WRITE goes directly to DONE. The error output is driven only by an illegal header.

Decomposition:
- Package imem_loader_pkg:
  - FSM state enum.
  - WORD_BYTES=4.
  - Lane-to-bit-slice constants.
  - Default BASE_ADDR and MAX_WORDS.
- Sub-module byte_assembler: 2-bit lane counter plus 32-bit shift register.
  - Inputs: byte, accept, clear.
  - Outputs: word, word_full.
- The FSM, address counter and word counter stay in imem_loader.

Test Plan:
- Reset, then start, then bytes 03, 20 09 00 02, 21 08 00 01, 15 09 FF FE:
  - Three mem_we pulses at addr 0/4/8 with data 32'h20090002 / 32'h21080001 / 32'h1509FFFE.
  - done=1, busy=0.
- Header 00 → error=1, no mem_we, busy low within 2 cycles. Header 8'd255 with MAX_WORDS=8 → same.
- Random in_valid gaps (50% duty) during the 2-word load → identical writes, no byte lost or duplicated. in_ready=0 during WRITE.
- reset_n pulsed low after 2 data bytes of word 1:
  - mem_we=0, FSM=IDLE.
  - A fresh load starting at BASE_ADDR succeeds.
- start pulsed mid-DATA → ignored; the load completes normally.
- Checksum (IMEM_LOADER_CHECKSUM_EN): word 32'h11223344 with checksum 8'h44 → done=1. Same word with checksum 8'h45 → error=1, done=0.
